// File: rtl/pulse_stretch_pkg.sv
// Shared constants and helpers for the pulse stretcher/synchroniser.
package pulse_stretch_pkg;

  localparam int RETRIG_DROP   = 0;
  localparam int RETRIG_RELOAD = 1;

  // Counter must hold STRETCH_LEN itself, hence len+1 states.
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/pulse_stretch_ch.sv
// One channel: optional resync chain, rising-edge detect, stretch counter and
// sticky flag for edges dropped while a stretch is already running.
module pulse_stretch_ch
  import pulse_stretch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_LEN = 3,
  parameter int IN_SYNC     = 1,
  parameter int RETRIG      = RETRIG_DROP
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pulse,
  input  logic i_miss_clr,
  output logic o_pulse,
  output logic o_miss
);

  localparam int CW = cnt_width(STRETCH_LEN);

  logic          s;
  logic          prev_q;
  logic          rise;
  logic          busy;
  logic          drop;
  logic [CW-1:0] cnt_q;
  logic          miss_q;

  generate
    if (IN_SYNC != 0) begin : g_sync
      (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], i_pulse};
      end
      assign s = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign s = i_pulse;
    end
  endgenerate

  // prev resets low so an input already high at release counts as one event.
  assign rise = s & ~prev_q;
  assign busy = (cnt_q != '0);
  assign drop = rise && busy && (RETRIG == RETRIG_DROP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      miss_q <= 1'b0;
    end else begin
      prev_q <= s;
      if (rise && (!busy || (RETRIG == RETRIG_RELOAD))) cnt_q <= CW'(STRETCH_LEN);
      else if (busy)                                    cnt_q <= cnt_q - CW'(1);
      // A new drop in the same cycle as a clear keeps the flag set.
      if (drop)            miss_q <= 1'b1;
      else if (i_miss_clr) miss_q <= 1'b0;
    end
  end

  assign o_pulse = busy;
  assign o_miss  = miss_q;

endmodule

// File: rtl/pulse_stretch_sync.sv
// Multi-channel pulse synchroniser/stretcher: CH independent channels plus a
// busy reduction and elaboration-time parameter checks.
module pulse_stretch_sync
  import pulse_stretch_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_LEN = 3,
  parameter int IN_SYNC     = 1,
  parameter int RETRIG      = RETRIG_DROP
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [CH-1:0] i_pulse,
  input  logic [CH-1:0] i_miss_clr,
  output logic [CH-1:0] o_pulse,
  output logic          o_busy,
  output logic [CH-1:0] o_miss
);

  generate
    if (CH < 1) begin : g_bad_ch
      $fatal(1, "pulse_stretch_sync: CH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $fatal(1, "pulse_stretch_sync: SYNC_STAGES must be >= 2");
    end
    if (STRETCH_LEN < 1) begin : g_bad_len
      $fatal(1, "pulse_stretch_sync: STRETCH_LEN must be >= 1");
    end
    if ((IN_SYNC != 0) && (IN_SYNC != 1)) begin : g_bad_insync
      $fatal(1, "pulse_stretch_sync: IN_SYNC must be 0 or 1");
    end
    if ((RETRIG != RETRIG_DROP) && (RETRIG != RETRIG_RELOAD)) begin : g_bad_retrig
      $fatal(1, "pulse_stretch_sync: RETRIG must be 0 or 1");
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
      pulse_stretch_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .STRETCH_LEN (STRETCH_LEN),
        .IN_SYNC     (IN_SYNC),
        .RETRIG      (RETRIG)
      ) u_ch (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_pulse    (i_pulse[c]),
        .i_miss_clr (i_miss_clr[c]),
        .o_pulse    (o_pulse[c]),
        .o_miss     (o_miss[c])
      );
    end
  endgenerate

  assign o_busy = |o_pulse;

endmodule

// File: tb/tb_pulse_stretch_sync.sv
// Directed bench for pulse_stretch_sync: three configurations share one clock
// and reset (defaults, retrigger with length 4, unsynchronised 8-channel).
module tb_pulse_stretch_sync;

  logic clk;
  logic rst_n;

  // default instance: CH=4, SYNC_STAGES=2, STRETCH_LEN=3, IN_SYNC=1, RETRIG=0
  logic [3:0] p_a, clr_a, op_a, om_a;
  logic       ob_a;
  // retrigger instance: STRETCH_LEN=4, RETRIG=1
  logic [3:0] p_r, clr_r, op_r, om_r;
  logic       ob_r;
  // sweep instance: CH=8, IN_SYNC=0, STRETCH_LEN=1
  logic [7:0] p_s, clr_s, op_s, om_s;
  logic       ob_s;

  int n_pass;
  int n_total;

  pulse_stretch_sync u_dut (
    .i_clk (clk), .i_rst_n (rst_n), .i_pulse (p_a), .i_miss_clr (clr_a),
    .o_pulse (op_a), .o_busy (ob_a), .o_miss (om_a)
  );

  pulse_stretch_sync #(.STRETCH_LEN (4), .RETRIG (1)) u_rt (
    .i_clk (clk), .i_rst_n (rst_n), .i_pulse (p_r), .i_miss_clr (clr_r),
    .o_pulse (op_r), .o_busy (ob_r), .o_miss (om_r)
  );

  pulse_stretch_sync #(.CH (8), .IN_SYNC (0), .STRETCH_LEN (1)) u_sw (
    .i_clk (clk), .i_rst_n (rst_n), .i_pulse (p_s), .i_miss_clr (clr_s),
    .o_pulse (op_s), .o_busy (ob_s), .o_miss (om_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: advance one clock, land 1 time unit past the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sweep reference model state
  logic [7:0] m_prev, m_cnt, m_miss;

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n = 1'b0;
    p_a = 4'hF; clr_a = '0;
    p_r = '0;   clr_r = '0;
    p_s = '0;   clr_s = '0;

    // 1: reset with all inputs high, then one 3-cycle pulse per channel
    repeat (3) step();
    check("rst_pulse", 32'(op_a), 32'h0);
    check("rst_miss",  32'(om_a), 32'h0);
    check("rst_busy",  32'(ob_a), 32'h0);
    rst_n = 1'b1;
    step();
    check("rel_e1", 32'(op_a), 32'h0);
    step();
    check("rel_e2", 32'(op_a), 32'h0);
    step();
    check("rel_e3", 32'(op_a), 32'hF);
    check("rel_busy", 32'(ob_a), 32'h1);
    step();
    check("rel_e4", 32'(op_a), 32'hF);
    step();
    check("rel_e5", 32'(op_a), 32'hF);
    step();
    check("rel_e6", 32'(op_a), 32'h0);
    check("rel_busy_lo", 32'(ob_a), 32'h0);
    p_a = '0;
    repeat (3) step();

    // 2: latency of a single-cycle event on ch0
    p_a[0] = 1'b1;
    step();
    p_a[0] = 1'b0;
    step();
    check("lat_e1", 32'(op_a), 32'h0);
    step();
    check("lat_e2", 32'(op_a), 32'h1);
    step();
    check("lat_e3", 32'(op_a), 32'h1);
    step();
    check("lat_e4", 32'(op_a), 32'h1);
    step();
    check("lat_e5", 32'(op_a), 32'h0);
    repeat (2) step();

    // 3: dropped second edge on ch1
    p_a[1] = 1'b1;
    step();
    p_a[1] = 1'b0;
    step();
    check("drop_e1", 32'(op_a), 32'h0);
    p_a[1] = 1'b1;
    step();
    p_a[1] = 1'b0;
    check("drop_e2", 32'(op_a), 32'h2);
    step();
    check("drop_e3", 32'(op_a), 32'h2);
    check("drop_miss_e3", 32'(om_a), 32'h0);
    step();
    check("drop_e4", 32'(op_a), 32'h2);
    check("drop_miss_e4", 32'(om_a), 32'h2);
    step();
    check("drop_e5", 32'(op_a), 32'h0);
    repeat (3) step();
    check("drop_miss_sticky", 32'(om_a), 32'h2);
    clr_a[1] = 1'b1;
    step();
    clr_a[1] = 1'b0;
    check("drop_miss_clr", 32'(om_a), 32'h0);
    repeat (3) step();
    // clear coincides with a fresh drop: set must win
    p_a[1] = 1'b1;
    step();
    p_a[1] = 1'b0;
    step();
    p_a[1] = 1'b1;
    step();
    p_a[1] = 1'b0;
    step();
    clr_a[1] = 1'b1;
    step();
    clr_a[1] = 1'b0;
    check("set_wins", 32'(om_a), 32'h2);
    clr_a[1] = 1'b1;
    step();
    clr_a[1] = 1'b0;
    check("set_wins_clr", 32'(om_a), 32'h0);
    check("set_wins_pulse", 32'(op_a), 32'h0);
    repeat (3) step();

    // 4: retrigger on ch2, edges 3 cycles apart -> 7 continuous cycles
    p_r[2] = 1'b1;
    step();
    p_r[2] = 1'b0;
    step();
    check("rt_e1", 32'(op_r), 32'h0);
    step();
    check("rt_e2", 32'(op_r), 32'h4);
    p_r[2] = 1'b1;
    step();
    p_r[2] = 1'b0;
    check("rt_e3", 32'(op_r), 32'h4);
    for (int i = 4; i <= 8; i++) begin
      step();
      check($sformatf("rt_e%0d", i), 32'(op_r), 32'h4);
    end
    step();
    check("rt_e9", 32'(op_r), 32'h0);
    check("rt_miss", 32'(om_r), 32'h0);
    repeat (2) step();

    // 5: asynchronous reset in the middle of a stretch
    p_a[0] = 1'b1;
    step();
    p_a[0] = 1'b0;
    step();
    step();
    check("mid_c1", 32'(op_a), 32'h1);
    step();
    check("mid_c2", 32'(op_a), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_async_pulse", 32'(op_a), 32'h0);
    check("mid_async_busy",  32'(ob_a), 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("mid_no_residue", 32'(op_a), 32'h0);
    end

    // 6: random sweep on the unsynchronised 8-channel instance
    m_prev = '0;
    m_cnt  = '0;
    m_miss = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      p_s   = 8'($urandom_range(0, 255));
      clr_s = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      for (int c = 0; c < 8; c++) begin
        logic e;
        e = p_s[c] & ~m_prev[c];
        if (e && m_cnt[c])     m_miss[c] = 1'b1;
        else if (clr_s[c])     m_miss[c] = 1'b0;
        if (e && !m_cnt[c])    m_cnt[c] = 1'b1;
        else                   m_cnt[c] = 1'b0;
        m_prev[c] = p_s[c];
      end
      step();
      check("sw_pulse", 32'(op_s), 32'(m_cnt));
      check("sw_miss",  32'(om_s), 32'(m_miss));
      check("sw_busy",  32'(ob_s), 32'(|m_cnt));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
